// File: rtl/bp_cce_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bp_cce_pkg
//  Description : Shared types and constants for the CCE microcode fetch
//                stage: instruction predecode fields and fetch FSM encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package bp_cce_pkg;

  // Widest microcode PC the instruction format can encode
  localparam int cce_inst_addr_width = 8;

  // Bit position of the predecode fields inside the instruction word
  localparam int cce_inst_target_offset = 0;

  // Predecode view of the low bits of an instruction word:
  // target in [7:0], predict_taken in [8], branch in [9]
  typedef struct packed {
    logic                           branch;
    logic                           predict_taken;
    logic [cce_inst_addr_width-1:0] target;
  } bp_cce_inst_s;

  typedef enum logic [1:0] {
    e_fetch_reset = 2'd0,
    e_fetch_load  = 2'd1,
    e_fetch_prime = 2'd2,
    e_fetch_fetch = 2'd3
  } bp_cce_fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/bp_cce_ucode_ram.sv
`default_nettype none
// ============================================================================
//  Module      : bp_cce_ucode_ram
//  Description : Single-port synchronous microcode RAM. One access per
//                cycle; reads return data the following cycle. A write
//                leaves the read data register untouched.
//  Revision    : 1.0  initial release
// ============================================================================
module bp_cce_ucode_ram #(
  parameter int ELS   = 256,
  parameter int WIDTH = 48,
  parameter int AW    = 8
) (
  input  logic             clk_i,
  input  logic             v_i,
  input  logic             w_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] r_mem [ELS];
  logic [WIDTH-1:0] r_data;

  // Write has priority over read; read data is registered
  always_ff @(posedge clk_i) begin
    if (v_i && w_i) begin
      r_mem[addr_i] <= data_i;
    end else if (v_i) begin
      r_data <= r_mem[addr_i];
    end
  end

  assign data_o = r_data;

endmodule
`default_nettype wire

// File: rtl/bp_cce_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bp_cce_fetch_ctrl
//  Description : CCE microcode fetch controller. Owns the fetch PC and the
//                microcode RAM, runs the load/prime/fetch sequence, predecodes
//                each fetched instruction to pick the next PC, and handles
//                decode stalls and execute-stage mispredict redirects.
//  Revision    : 1.0  initial release
// ============================================================================
module bp_cce_fetch_ctrl
  import bp_cce_pkg::*;
#(
  parameter int num_inst_p   = 256,
  parameter int inst_width_p = 48,
  localparam int addr_width  = $clog2(num_inst_p)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    cfg_w_v_i,
  input  logic                    cfg_r_v_i,
  input  logic [addr_width-1:0]   cfg_addr_i,
  input  logic [inst_width_p-1:0] cfg_data_i,
  output logic [inst_width_p-1:0] cfg_data_o,
  output logic                    cfg_data_v_o,
  input  logic                    start_i,
  input  logic                    stall_i,
  input  logic                    mispredict_i,
  input  logic [addr_width-1:0]   mispredict_pc_i,
  output logic [inst_width_p-1:0] inst_o,
  output logic                    inst_v_o,
  output logic [addr_width-1:0]   pc_o
);

  localparam logic [1:0] c_st_reset = e_fetch_reset;
  localparam logic [1:0] c_st_load  = e_fetch_load;
  localparam logic [1:0] c_st_prime = e_fetch_prime;
  localparam logic [1:0] c_st_fetch = e_fetch_fetch;

  logic [1:0]              r_state;
  logic [1:0]              w_state_n;
  logic [addr_width-1:0]   r_fpc;
  logic                    r_cfg_data_v;

  logic [inst_width_p-1:0] w_ram_data;
  logic                    w_ram_v;
  logic                    w_ram_w;
  logic [addr_width-1:0]   w_ram_addr;

  bp_cce_inst_s            w_inst;
  logic                    w_taken;
  logic [addr_width-1:0]   w_pred_pc;
  logic [addr_width-1:0]   w_next_pc;

  logic                    w_in_load;
  logic                    w_cfg_any;

  assign w_in_load = (r_state == c_st_load);
  assign w_cfg_any = cfg_w_v_i | cfg_r_v_i;

  // Predecode only looks at the low instruction bits
  assign w_inst = bp_cce_inst_s'(w_ram_data[cce_inst_target_offset +: $bits(bp_cce_inst_s)]);

  // Predecode and next-PC priority mux: redirect, then stall, then prediction
  always_comb begin
    w_taken   = w_inst.branch & w_inst.predict_taken;
    w_pred_pc = w_taken ? w_inst.target[addr_width-1:0] : r_fpc + addr_width'(1);
    if (mispredict_i) begin
      w_next_pc = mispredict_pc_i;
    end else if (stall_i) begin
      w_next_pc = r_fpc;
    end else begin
      w_next_pc = w_pred_pc;
    end
  end

  // Next-state logic; a cfg strobe in LOAD takes precedence over start
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      c_st_reset: w_state_n = c_st_load;
      c_st_load:  if (start_i && !w_cfg_any) w_state_n = c_st_prime;
      c_st_prime: w_state_n = c_st_fetch;
      c_st_fetch: w_state_n = c_st_fetch;
      default:    w_state_n = c_st_load;
    endcase
  end

  // Single RAM port shared between cfg access and instruction fetch
  always_comb begin
    w_ram_v    = 1'b0;
    w_ram_w    = 1'b0;
    w_ram_addr = '0;
    case (r_state)
      c_st_load: begin
        w_ram_v    = w_cfg_any;
        w_ram_w    = cfg_w_v_i;
        w_ram_addr = cfg_addr_i;
      end
      c_st_prime: begin
        w_ram_v    = 1'b1;
        w_ram_addr = '0;
      end
      c_st_fetch: begin
        w_ram_v    = 1'b1;
        w_ram_addr = w_next_pc;
      end
      default: begin
        w_ram_v = 1'b0;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_state <= c_st_reset;
    else         r_state <= w_state_n;
  end

  // Fetch PC tracks the RAM address so pc_o always names inst_o
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_fpc <= '0;
    end else if (r_state == c_st_prime) begin
      r_fpc <= '0;
    end else if (r_state == c_st_fetch) begin
      r_fpc <= w_next_pc;
    end
  end

  // Read-back valid for a cfg read that was not overridden by a write
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_cfg_data_v <= 1'b0;
    else         r_cfg_data_v <= w_in_load & cfg_r_v_i & ~cfg_w_v_i;
  end

  bp_cce_ucode_ram #(
    .ELS   (num_inst_p),
    .WIDTH (inst_width_p),
    .AW    (addr_width)
  ) u_ram (
    .clk_i  (clk_i),
    .v_i    (w_ram_v),
    .w_i    (w_ram_w),
    .addr_i (w_ram_addr),
    .data_i (cfg_data_i),
    .data_o (w_ram_data)
  );

  assign inst_o       = w_ram_data;
  assign inst_v_o     = (r_state == c_st_fetch);
  assign pc_o         = r_fpc;
  assign cfg_data_o   = w_ram_data;
  assign cfg_data_v_o = r_cfg_data_v;

endmodule
`default_nettype wire

// File: tb/tb_bp_cce_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bp_cce_fetch_ctrl
//  Description : Directed self-checking bench for bp_cce_fetch_ctrl with an
//                8-entry microcode RAM.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bp_cce_fetch_ctrl;

  localparam int NI = 8;
  localparam int IW = 48;
  localparam int AW = 3;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          cfg_w_v_i;
  logic          cfg_r_v_i;
  logic [AW-1:0] cfg_addr_i;
  logic [IW-1:0] cfg_data_i;
  logic [IW-1:0] cfg_data_o;
  logic          cfg_data_v_o;
  logic          start_i;
  logic          stall_i;
  logic          mispredict_i;
  logic [AW-1:0] mispredict_pc_i;
  logic [IW-1:0] inst_o;
  logic          inst_v_o;
  logic [AW-1:0] pc_o;

  logic [IW-1:0] exp_mem [NI];
  int            n_tests = 0;
  int            n_fail  = 0;
  logic [IW-1:0] held_inst;

  bp_cce_fetch_ctrl #(
    .num_inst_p   (NI),
    .inst_width_p (IW)
  ) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .cfg_w_v_i       (cfg_w_v_i),
    .cfg_r_v_i       (cfg_r_v_i),
    .cfg_addr_i      (cfg_addr_i),
    .cfg_data_i      (cfg_data_i),
    .cfg_data_o      (cfg_data_o),
    .cfg_data_v_o    (cfg_data_v_o),
    .start_i         (start_i),
    .stall_i         (stall_i),
    .mispredict_i    (mispredict_i),
    .mispredict_pc_i (mispredict_pc_i),
    .inst_o          (inst_o),
    .inst_v_o        (inst_v_o),
    .pc_o            (pc_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [IW-1:0] obs, input logic [IW-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic cfg_write(input int addr, input logic [IW-1:0] data);
    cfg_w_v_i  = 1'b1;
    cfg_addr_i = AW'(addr);
    cfg_data_i = data;
    tick();
    cfg_w_v_i  = 1'b0;
    exp_mem[addr] = data;
  endtask

  task automatic cfg_read_check(input string tag, input int addr);
    cfg_r_v_i  = 1'b1;
    cfg_addr_i = AW'(addr);
    tick();
    cfg_r_v_i  = 1'b0;
    check({tag, "_v"}, IW'(cfg_data_v_o), IW'(1));
    check({tag, "_data"}, cfg_data_o, exp_mem[addr]);
  endtask

  task automatic expect_fetch(input string tag, input int pc);
    check({tag, "_v"}, IW'(inst_v_o), IW'(1));
    check({tag, "_pc"}, IW'(pc_o), IW'(pc));
    check({tag, "_inst"}, inst_o, exp_mem[pc]);
  endtask

  // start in LOAD, PRIME next cycle, first instruction (PC 0) after that
  task automatic start_fetch(input string tag);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check({tag, "_prime_v"}, IW'(inst_v_o), IW'(0));
    tick();
    expect_fetch({tag, "_f0"}, 0);
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    tick();
    tick();
    reset_i = 1'b0;
    tick();  // leaves RESET, now in LOAD
  endtask

  initial begin
    reset_i = 1'b1;
    cfg_w_v_i = 1'b0; cfg_r_v_i = 1'b0; cfg_addr_i = '0; cfg_data_i = '0;
    start_i = 1'b0; stall_i = 1'b0; mispredict_i = 1'b0; mispredict_pc_i = '0;
    tick();
    tick();
    check("rst_inst_v", IW'(inst_v_o), IW'(0));
    check("rst_cfg_v", IW'(cfg_data_v_o), IW'(0));
    check("rst_pc", IW'(pc_o), IW'(0));
    reset_i = 1'b0;
    tick();

    // Load a straight-line program; address 3 holds the read-back pattern
    for (int i = 0; i < NI; i++) begin
      if (i == 3) cfg_write(i, 48'hA5A5);
      else        cfg_write(i, 48'hABCD_0000_0000 | (48'(i) << 16));
    end
    check("load_inst_v", IW'(inst_v_o), IW'(0));
    cfg_read_check("rb3", 3);
    tick();
    check("rb_one_cycle", IW'(cfg_data_v_o), IW'(0));

    // Simultaneous write and read: write wins, no read-back
    cfg_w_v_i = 1'b1; cfg_r_v_i = 1'b1; cfg_addr_i = 3'd5;
    cfg_data_i = 48'h5555_0000_0000;
    tick();
    cfg_w_v_i = 1'b0; cfg_r_v_i = 1'b0;
    exp_mem[5] = 48'h5555_0000_0000;
    check("wr_rd_no_v", IW'(cfg_data_v_o), IW'(0));
    cfg_read_check("rb5", 5);

    // Sequential fetch with wrap; a cfg read during FETCH is ignored
    start_fetch("seq");
    for (int p = 1; p <= 8; p++) begin
      if (p == 8) begin
        cfg_r_v_i = 1'b1; cfg_addr_i = 3'd3;
      end
      tick();
      expect_fetch($sformatf("seq%0d", p), p % NI);
    end
    cfg_r_v_i = 1'b0;
    tick();
    check("fetch_cfg_rd_v", IW'(cfg_data_v_o), IW'(0));
    check("seq_pc1", IW'(pc_o), IW'(1));
    for (int p = 2; p <= 4; p++) begin
      tick();
      check($sformatf("seq_pc%0d", p), IW'(pc_o), IW'(p));
    end

    // Stall for 3 cycles at PC 4
    held_inst = inst_o;
    stall_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("stall_pc%0d", k), IW'(pc_o), IW'(4));
      check($sformatf("stall_inst%0d", k), inst_o, held_inst);
      check($sformatf("stall_v%0d", k), IW'(inst_v_o), IW'(1));
    end
    stall_i = 1'b0;
    tick();
    expect_fetch("post_stall", 5);

    // Mispredict together with stall at PC 5: redirect wins
    mispredict_i = 1'b1; mispredict_pc_i = 3'd1; stall_i = 1'b1;
    tick();
    mispredict_i = 1'b0; stall_i = 1'b0;
    expect_fetch("mp", 1);
    tick();
    expect_fetch("mp_next", 2);
    tick();
    check("pre_rst_pc", IW'(pc_o), IW'(3));

    // Asynchronous reset in the middle of a cycle
    #2;
    reset_i = 1'b1;
    #1;
    check("async_rst_v", IW'(inst_v_o), IW'(0));
    check("async_rst_pc", IW'(pc_o), IW'(0));
    tick();
    tick();
    reset_i = 1'b0;
    tick();
    check("rst_load_v", IW'(inst_v_o), IW'(0));
    cfg_read_check("keep3", 3);
    cfg_read_check("keep6", 6);

    // Taken branch at PC 2 to 6; high target bits must be ignored
    cfg_write(2, 48'h3FE);
    start_fetch("br");
    tick(); expect_fetch("br1", 1);
    tick(); expect_fetch("br2", 2);
    tick(); expect_fetch("br6", 6);
    tick(); expect_fetch("br7", 7);

    // Same branch predicted not-taken falls through
    do_reset();
    cfg_write(2, 48'h2FE);
    start_fetch("nt");
    tick(); expect_fetch("nt1", 1);
    tick(); expect_fetch("nt2", 2);
    tick(); expect_fetch("nt3", 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
